axi_mem_responder: RTL and testbench
====================================

Name: axi_mem_responder

Overview:
- AXI4 memory-mapped responder (slave) backed by on-chip byte-enable RAM.
- It is the far end of the gmem master interface that the kernel-level read and write masters drive.
- Used as the gmem target in kernel-level benches, and as an on-chip scratch memory.
- Serves INCR bursts on independent read and write channels.

Parameters:
- C_ADDR_WIDTH, 64, AXI address width.
- C_DATA_WIDTH, 512, AXI data width; power of two, at least 32.
- C_ID_WIDTH, 1, AXI ID width.
- C_MEM_DEPTH_LOG2, 10, log2 of RAM depth in C_DATA_WIDTH words.

Ports:
- ap_clk  in  1  clock
- areset  in  1  synchronous active-high reset
- s_axi_awvalid/awready  in/out  1/1  write-address handshake
- s_axi_awaddr  in  C_ADDR_WIDTH  burst byte address
- s_axi_awid  in  C_ID_WIDTH  write ID
- s_axi_awlen  in  8  beats-1
- s_axi_wvalid/wready  in/out  1/1  write-data handshake
- s_axi_wdata  in  C_DATA_WIDTH  write data
- s_axi_wstrb  in  C_DATA_WIDTH/8  byte enables
- s_axi_wlast  in  1  last write beat
- s_axi_bvalid/bready  out/in  1/1  response handshake
- s_axi_bresp  out  2  write response
- s_axi_bid  out  C_ID_WIDTH  echoed AWID
- s_axi_arvalid/arready  in/out  1/1  read-address handshake
- s_axi_araddr  in  C_ADDR_WIDTH  burst byte address
- s_axi_arid  in  C_ID_WIDTH  read ID
- s_axi_arlen  in  8  beats-1
- s_axi_rvalid/rready  out/in  1/1  read-data handshake
- s_axi_rdata  out  C_DATA_WIDTH  read data
- s_axi_rresp  out  2  read response
- s_axi_rlast  out  1  last read beat
- s_axi_rid  out  C_ID_WIDTH  echoed ARID

Behaviour:
- Clock and reset (already decided): reset areset, synchronous, active-high; clock ap_clk.
- Reset values: all valid and ready outputs 0; bresp, rresp, bid, rid, rdata and rlast 0.
- Reset is honoured mid-burst: both FSMs return to IDLE, the outstanding burst is dropped, and RAM contents are retained.
- Burst and size handling:
  - Burst type is always INCR at full-width size; AWSIZE and ARSIZE are not ports.
  - Word index = addr[C_MEM_DEPTH_LOG2+LB-1:LB], where LB = log2(C_DATA_WIDTH/8).
  - The low LB address bits are ignored.
  - The word index increments per beat and wraps modulo 2^C_MEM_DEPTH_LOG2.
- Write FSM, states W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. The AW handshake latches index, len and id, then moves to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the RAM at the current index with wstrb byte enables, then increments beat count and index.
  - On the beat where count==len, move to W_RESP.
  - If wlast disagrees with count==len on any beat, set a sticky error flag. The burst still terminates on count==len.
  - W_RESP: bvalid=1, bid=latched id, bresp=OKAY (2'b00), or SLVERR (2'b10) if the error flag is set.
  - On bready, return to W_IDLE. bvalid holds until accepted.
- Read FSM, states R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1 (0 in R_DATA). The AR handshake latches index, len and id.
  - RAM read latency is 1 cycle. An output register plus a one-entry skid register sustain one beat per cycle.
  - An AR handshake in cycle T gives the first rvalid in cycle T+2.
  - With rready held high, beats are back-to-back.
  - rdata, rlast and rid are held stable while rvalid=1 and rready=0.
  - rlast=1 on beat len. Its handshake returns the FSM to R_IDLE, so the next arready comes the following cycle.
  - rresp=OKAY.
- Read and write channels are fully independent.
- Same-word read and write in the same cycle: the read returns the old data (read-first).
- Only one burst is outstanding per channel; no reordering.

Optional Feature:
- Macro: AXI_MEM_RESPONDER_BOUNDS_CHECK_EN.
- Defined:
  - A burst whose start address bits above the RAM range (addr[C_ADDR_WIDTH-1:C_MEM_DEPTH_LOG2+LB]) are nonzero is out of range.
  - Also out of range: a burst with index+len > 2^C_MEM_DEPTH_LOG2-1.
  - For an out-of-range burst, writes are suppressed and bresp=SLVERR.
  - For an out-of-range burst, reads return rdata=0 with rresp=SLVERR on every beat.
  - Beat counts and handshakes are unchanged.
- Undefined: upper address bits are ignored, the index wraps, and responses are always OKAY except the wlast-mismatch SLVERR.

Decomposition:
- Package axi_mem_responder_pkg holds:
  - resp codes RESP_OKAY and RESP_SLVERR;
  - write FSM enum (W_IDLE, W_DATA, W_RESP);
  - read FSM enum (R_IDLE, R_DATA);
  - function for LB derivation.
- Sub-module axi_mem_responder_ram: simple dual-port RAM.
  - Port A: write with byte enables.
  - Port B: registered read, read-first.
  - Instantiated once.

Test Plan:
- Write test: AW addr=0x0, len=3, 4 beats with wdata=k, wstrb all ones, wlast on beat 3.
  - Response: bvalid with bresp=0 and bid=awid.
  - Readback AR addr=0x0, len=3 returns 0,1,2,3 with rlast on the 4th beat.
  - First rvalid arrives 2 cycles after the AR handshake.
- Byte-enable merge: write 0xFF..FF to word 5.
  - Then write 0 with wstrb=1 at addr=0x140.
  - Read of word 5 returns all ones except byte 0 = 0x00.
- Backpressure: read len=7 with rready toggling 1,0,0,1.
  - rdata and rlast stay stable while stalled.
  - All 8 beats arrive in order with no loss.
- Error and wrap (macro undefined):
  - Write len=1 with wlast on beat 0 -> bresp=2'b10.
  - Burst at index 1023, len=1 writes words 1023 and 0.
- Bounds (macro defined): araddr=0x10000, len=0 -> rresp=2'b10 and rdata=0.
- Reset mid-burst: assert areset after beat 2 of an 8-beat read.
  - All valids go to 0 on the next cycle.
  - After reset, a new burst completes correctly and previously written data is intact.

Source files
------------

// File: rtl/axi_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_mem_responder_pkg
//  Purpose  : Shared response codes, FSM state types and lane-width helper
//             for the AXI4 memory responder.
//  Revision : 1.0  initial release
// ============================================================================
package axi_mem_responder_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Number of byte-offset address bits within one data word.
    function automatic int lb_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_mem_responder_if
//  Purpose  : AXI4 (INCR, full-width) signal bundle between a gmem master
//             and the memory responder.
//  Revision : 1.0  initial release
// ============================================================================
interface axi_mem_responder_if #(
    parameter int C_ADDR_WIDTH = 64,
    parameter int C_DATA_WIDTH = 512,
    parameter int C_ID_WIDTH   = 1
);
    logic                      awvalid;
    logic                      awready;
    logic [C_ADDR_WIDTH-1:0]   awaddr;
    logic [C_ID_WIDTH-1:0]     awid;
    logic [7:0]                awlen;
    logic                      wvalid;
    logic                      wready;
    logic [C_DATA_WIDTH-1:0]   wdata;
    logic [C_DATA_WIDTH/8-1:0] wstrb;
    logic                      wlast;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic [C_ID_WIDTH-1:0]     bid;
    logic                      arvalid;
    logic                      arready;
    logic [C_ADDR_WIDTH-1:0]   araddr;
    logic [C_ID_WIDTH-1:0]     arid;
    logic [7:0]                arlen;
    logic                      rvalid;
    logic                      rready;
    logic [C_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic [C_ID_WIDTH-1:0]     rid;

    modport master (
        output awvalid, awaddr, awid, awlen, wvalid, wdata, wstrb, wlast, bready,
               arvalid, araddr, arid, arlen, rready,
        input  awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp,
               rlast, rid
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, wvalid, wdata, wstrb, wlast, bready,
               arvalid, araddr, arid, arlen, rready,
        output awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp,
               rlast, rid
    );
endinterface
`default_nettype wire

// File: rtl/axi_mem_responder_ram.sv
`default_nettype none
// ============================================================================
//  Module   : axi_mem_responder_ram
//  Purpose  : Simple dual-port RAM. Port A writes with byte enables, port B
//             reads with one cycle of latency and returns the old word when
//             both ports hit the same address in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module axi_mem_responder_ram #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_BITS  = 10
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDR_BITS-1:0]    waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    re,
    input  logic [ADDR_BITS-1:0]    raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);
    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_BITS)-1];

    // Byte-lane write port.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Registered read port; non-blocking update gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule
`default_nettype wire

// File: rtl/axi_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : axi_mem_responder
//  Purpose  : AXI4 slave backed by on-chip byte-enable RAM. Independent read
//             and write INCR burst engines, one burst outstanding each.
//  Options  : AXI_MEM_RESPONDER_BOUNDS_CHECK_EN - flag bursts that leave the
//             RAM range with SLVERR, suppress their writes, zero their reads.
//  Revision : 1.0  initial release
// ============================================================================
module axi_mem_responder
    import axi_mem_responder_pkg::*;
#(
    parameter int C_ADDR_WIDTH     = 64,
    parameter int C_DATA_WIDTH     = 512,
    parameter int C_ID_WIDTH       = 1,
    parameter int C_MEM_DEPTH_LOG2 = 10
) (
    input  logic               ap_clk,
    input  logic               areset,
    axi_mem_responder_if.slave s_axi
);
    localparam int LB = lb_bits(C_DATA_WIDTH);
    localparam int MD = C_MEM_DEPTH_LOG2;

    typedef logic [MD-1:0] idx_t;

    wr_state_t               wr_state, wr_state_next;
    idx_t                    wr_idx, aw_idx;
    logic [7:0]              wr_len, wr_cnt;
    logic [C_ID_WIDTH-1:0]   wr_id;
    logic                    wr_err, wr_oor, aw_oor, aw_hs, w_hs;

    rd_state_t               rd_state, rd_state_next;
    idx_t                    rd_idx, ar_idx, ram_raddr;
    logic [7:0]              rd_len, rd_cnt;
    logic [C_ID_WIDTH-1:0]   rd_id;
    logic                    rd_oor, rd_done, ar_oor, ar_hs;
    logic                    issue_more, ram_re, issue_last, issue_err;
    logic [C_DATA_WIDTH-1:0] ram_rdata, p1_data, out_data, skid_data;
    logic                    p1_valid, p1_last, p1_err;
    logic                    out_valid, out_last, out_err;
    logic                    skid_valid, skid_last, skid_err;
    logic                    pop, load_out;
    logic [1:0]              held;

    assign aw_idx = s_axi.awaddr[MD+LB-1:LB];
    assign ar_idx = s_axi.araddr[MD+LB-1:LB];

`ifdef AXI_MEM_RESPONDER_BOUNDS_CHECK_EN
    // Out of range: start address above the RAM, or burst running past its last word.
    assign aw_oor = ((s_axi.awaddr >> (MD + LB)) != '0) ||
                    ((32'(aw_idx) + 32'(s_axi.awlen)) > 32'((2 ** MD) - 1));
    assign ar_oor = ((s_axi.araddr >> (MD + LB)) != '0) ||
                    ((32'(ar_idx) + 32'(s_axi.arlen)) > 32'((2 ** MD) - 1));
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
`endif

    // ---------------- write channel ----------------
    assign aw_hs     = s_axi.awvalid && s_axi.awready;
    assign w_hs      = s_axi.wvalid && s_axi.wready;
    assign s_axi.bid = wr_id;

    // Write FSM state register.
    always_ff @(posedge ap_clk) begin
        if (areset) wr_state <= W_IDLE;
        else        wr_state <= wr_state_next;
    end

    // Write FSM next state and channel handshake outputs; readies held low in reset.
    always_comb begin
        wr_state_next = wr_state;
        s_axi.awready = 1'b0;
        s_axi.wready  = 1'b0;
        s_axi.bvalid  = 1'b0;
        s_axi.bresp   = RESP_OKAY;
        case (wr_state)
            W_IDLE: begin
                s_axi.awready = !areset;
                if (s_axi.awvalid && !areset) wr_state_next = W_DATA;
            end
            W_DATA: begin
                s_axi.wready = !areset;
                if (s_axi.wvalid && !areset && (wr_cnt == wr_len)) wr_state_next = W_RESP;
            end
            W_RESP: begin
                s_axi.bvalid = 1'b1;
                s_axi.bresp  = wr_err ? RESP_SLVERR : RESP_OKAY;
                if (s_axi.bready) wr_state_next = W_IDLE;
            end
            default: wr_state_next = W_IDLE;
        endcase
    end

    // Write burst context: latch on AW, advance per beat, accumulate wlast errors.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            wr_idx <= '0;
            wr_len <= '0;
            wr_cnt <= '0;
            wr_id  <= '0;
            wr_err <= 1'b0;
            wr_oor <= 1'b0;
        end else if (aw_hs) begin
            wr_idx <= aw_idx;
            wr_len <= s_axi.awlen;
            wr_cnt <= '0;
            wr_id  <= s_axi.awid;
            wr_err <= aw_oor;
            wr_oor <= aw_oor;
        end else if (w_hs) begin
            wr_idx <= wr_idx + 1'b1;
            wr_cnt <= wr_cnt + 1'b1;
            if (s_axi.wlast != (wr_cnt == wr_len)) wr_err <= 1'b1;
        end
    end

    // ---------------- read channel ----------------
    // The first beat is issued to the RAM in the AR handshake cycle itself so
    // data reaches the output register two cycles later. Further beats are
    // issued only while output+skid can absorb everything still in flight.
    assign ar_hs      = s_axi.arvalid && s_axi.arready;
    assign pop        = out_valid && s_axi.rready;
    assign load_out   = !out_valid || s_axi.rready;
    assign held       = 2'(out_valid) + 2'(skid_valid) + 2'(p1_valid) - 2'(pop);
    assign issue_more = (rd_state == R_DATA) && !rd_done && (held <= 2'd1);
    assign ram_re     = ar_hs || issue_more;
    assign ram_raddr  = ar_hs ? ar_idx : rd_idx;
    assign issue_last = ar_hs ? (s_axi.arlen == 8'd0) : (rd_cnt == rd_len);
    assign issue_err  = ar_hs ? ar_oor : rd_oor;
    assign p1_data    = p1_err ? '0 : ram_rdata;

    assign s_axi.rvalid = out_valid;
    assign s_axi.rdata  = out_data;
    assign s_axi.rlast  = out_last;
    assign s_axi.rresp  = out_err ? RESP_SLVERR : RESP_OKAY;
    assign s_axi.rid    = rd_id;

    // Read FSM state register.
    always_ff @(posedge ap_clk) begin
        if (areset) rd_state <= R_IDLE;
        else        rd_state <= rd_state_next;
    end

    // Read FSM next state; burst ends when the rlast beat is accepted.
    always_comb begin
        rd_state_next = rd_state;
        s_axi.arready = 1'b0;
        case (rd_state)
            R_IDLE: begin
                s_axi.arready = !areset;
                if (s_axi.arvalid && !areset) rd_state_next = R_DATA;
            end
            R_DATA: begin
                if (pop && out_last) rd_state_next = R_IDLE;
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

    // Read burst context: latch on AR, advance per issued beat.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            rd_idx  <= '0;
            rd_len  <= '0;
            rd_cnt  <= '0;
            rd_id   <= '0;
            rd_oor  <= 1'b0;
            rd_done <= 1'b0;
        end else if (ar_hs) begin
            rd_idx  <= ar_idx + 1'b1;
            rd_len  <= s_axi.arlen;
            rd_cnt  <= 8'd1;
            rd_id   <= s_axi.arid;
            rd_oor  <= ar_oor;
            rd_done <= (s_axi.arlen == 8'd0);
        end else if (issue_more) begin
            rd_idx <= rd_idx + 1'b1;
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_cnt == rd_len) rd_done <= 1'b1;
        end
    end

    // Data pipeline: RAM stage tags, output register and one-entry skid.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            p1_valid   <= 1'b0;
            p1_last    <= 1'b0;
            p1_err     <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_err    <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
            skid_err   <= 1'b0;
        end else begin
            p1_valid <= ram_re;
            p1_last  <= issue_last;
            p1_err   <= issue_err;
            if (load_out) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_data   <= skid_data;
                    out_last   <= skid_last;
                    out_err    <= skid_err;
                    skid_valid <= p1_valid;
                    skid_data  <= p1_data;
                    skid_last  <= p1_last;
                    skid_err   <= p1_err;
                end else begin
                    out_valid <= p1_valid;
                    out_data  <= p1_data;
                    out_last  <= p1_last;
                    out_err   <= p1_err;
                end
            end else if (p1_valid) begin
                skid_valid <= 1'b1;
                skid_data  <= p1_data;
                skid_last  <= p1_last;
                skid_err   <= p1_err;
            end
        end
    end

    axi_mem_responder_ram #(
        .DATA_WIDTH (C_DATA_WIDTH),
        .ADDR_BITS  (MD)
    ) u_ram (
        .clk   (ap_clk),
        .we    (w_hs && !wr_oor),
        .waddr (wr_idx),
        .wdata (s_axi.wdata),
        .wstrb (s_axi.wstrb),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );
endmodule
`default_nettype wire

// File: tb/tb_axi_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_mem_responder
//  Purpose  : Scoreboard bench for axi_mem_responder (default parameters).
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi_mem_responder;

    typedef struct {
        logic [511:0] data;
        logic         last;
        logic [1:0]   resp;
        logic [0:0]   id;
    } r_exp_t;

    typedef struct {
        logic [1:0] resp;
        logic [0:0] id;
    } b_exp_t;

    logic ap_clk = 1'b0;
    logic areset = 1'b1;

    axi_mem_responder_if #(.C_ADDR_WIDTH(64), .C_DATA_WIDTH(512), .C_ID_WIDTH(1)) s_axi ();

    axi_mem_responder #(
        .C_ADDR_WIDTH     (64),
        .C_DATA_WIDTH     (512),
        .C_ID_WIDTH       (1),
        .C_MEM_DEPTH_LOG2 (10)
    ) dut (
        .ap_clk (ap_clk),
        .areset (areset),
        .s_axi  (s_axi)
    );

    always #5 ap_clk = ~ap_clk;

    r_exp_t       exp_r[$];
    b_exp_t       exp_b[$];
    logic [511:0] model [0:1023];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           r_beats  = 0;
    int           rr_mode  = 0;
    logic         r_stalled = 1'b0;
    logic [511:0] held_data;
    logic         held_last;
    r_exp_t       re_pop;
    b_exp_t       be_pop;

    task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: observed %0h required %0h", tag, obs, expv);
    endtask

    function automatic logic addr_oor(input logic [63:0] addr, input logic [7:0] len);
`ifdef AXI_MEM_RESPONDER_BOUNDS_CHECK_EN
        return (addr[63:16] != '0) || ((int'(addr[15:6]) + int'(len)) > 1023);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic ready_of(input int ch);
        case (ch)
            0:       return s_axi.awready;
            1:       return s_axi.wready;
            default: return s_axi.arready;
        endcase
    endfunction

    // Called at posedge+1 with valid already driven; returns at posedge+1 after the handshake.
    task automatic wait_ready(input int ch, input string tag);
        int n = 0;
        while (!ready_of(ch) && n < 100) begin
            @(posedge ap_clk); #1;
            n++;
        end
        check_val({tag, "_ready"}, ready_of(ch), 1);
        @(posedge ap_clk); #1;
    endtask

    task automatic write_burst(input logic [63:0] addr, input logic [7:0] len, input logic [0:0] id,
                               input logic [511:0] seed, input logic [63:0] strb, input bit bad_last);
        b_exp_t       e;
        logic         oor;
        int           idx;
        logic [511:0] d;
        oor    = addr_oor(addr, len);
        idx    = int'(addr[15:6]);
        e.resp = (oor || bad_last) ? 2'b10 : 2'b00;
        e.id   = id;
        exp_b.push_back(e);
        s_axi.awaddr  = addr;
        s_axi.awlen   = len;
        s_axi.awid    = id;
        s_axi.awvalid = 1'b1;
        wait_ready(0, "aw");
        s_axi.awvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            d            = seed + 512'(k);
            s_axi.wdata  = d;
            s_axi.wstrb  = strb;
            s_axi.wlast  = bad_last ? (k == 0) : (k == int'(len));
            s_axi.wvalid = 1'b1;
            wait_ready(1, "w");
            if (!oor) begin
                for (int b = 0; b < 64; b++) begin
                    if (strb[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
                end
            end
            idx = (idx + 1) % 1024;
        end
        s_axi.wvalid = 1'b0;
        s_axi.wlast  = 1'b0;
    endtask

    task automatic read_burst(input logic [63:0] addr, input logic [7:0] len, input logic [0:0] id,
                              input bit check_lat);
        r_exp_t e;
        logic   oor;
        int     idx;
        oor = addr_oor(addr, len);
        idx = int'(addr[15:6]);
        for (int k = 0; k <= int'(len); k++) begin
            e.data = oor ? '0 : model[idx];
            e.last = (k == int'(len));
            e.resp = oor ? 2'b10 : 2'b00;
            e.id   = id;
            exp_r.push_back(e);
            idx = (idx + 1) % 1024;
        end
        s_axi.araddr  = addr;
        s_axi.arlen   = len;
        s_axi.arid    = id;
        s_axi.arvalid = 1'b1;
        wait_ready(2, "ar");
        s_axi.arvalid = 1'b0;
        if (check_lat) begin
            check_val("r_lat_t1", s_axi.rvalid, 0);
            @(posedge ap_clk); #1;
            check_val("r_lat_t2", s_axi.rvalid, 1);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_r.size() + exp_b.size()) != 0 && n < 300) begin
            @(posedge ap_clk); #1;
            n++;
        end
        check_val({tag, "_drain"}, exp_r.size() + exp_b.size(), 0);
    endtask

    // rready pattern: 0 = held high, 1 = toggling 1,0,0,1, otherwise held low.
    initial begin : rready_drv
        int ph;
        ph = 0;
        s_axi.rready = 1'b0;
        forever begin
            @(posedge ap_clk); #2;
            case (rr_mode)
                0:       s_axi.rready = 1'b1;
                1: begin
                    s_axi.rready = ((ph % 4) == 0) || ((ph % 4) == 3);
                    ph++;
                end
                default: s_axi.rready = 1'b0;
            endcase
        end
    end

    // Response monitor: pops scoreboard on each R/B handshake, checks stall stability.
    always @(negedge ap_clk) begin
        if (areset) begin
            r_stalled = 1'b0;
        end else begin
            if (s_axi.rvalid) begin
                if (r_stalled) begin
                    check_val("r_hold_data", s_axi.rdata, held_data);
                    check_val("r_hold_last", s_axi.rlast, held_last);
                end
                if (s_axi.rready) begin
                    if (exp_r.size() == 0) begin
                        check_val("r_unexpected", exp_r.size(), 1);
                    end else begin
                        re_pop = exp_r.pop_front();
                        check_val("r_data", s_axi.rdata, re_pop.data);
                        check_val("r_last", s_axi.rlast, re_pop.last);
                        check_val("r_resp", s_axi.rresp, re_pop.resp);
                        check_val("r_id",   s_axi.rid,   re_pop.id);
                    end
                    r_beats++;
                    r_stalled = 1'b0;
                end else begin
                    r_stalled = 1'b1;
                    held_data = s_axi.rdata;
                    held_last = s_axi.rlast;
                end
            end else if (r_stalled) begin
                check_val("r_valid_drop", s_axi.rvalid, 1);
                r_stalled = 1'b0;
            end
            if (s_axi.bvalid && s_axi.bready) begin
                if (exp_b.size() == 0) begin
                    check_val("b_unexpected", exp_b.size(), 1);
                end else begin
                    be_pop = exp_b.pop_front();
                    check_val("b_resp", s_axi.bresp, be_pop.resp);
                    check_val("b_id",   s_axi.bid,   be_pop.id);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        int n;
        for (int i = 0; i < 1024; i++) model[i] = '0;
        s_axi.awvalid = 1'b0; s_axi.awaddr = '0; s_axi.awid = '0; s_axi.awlen = '0;
        s_axi.wvalid  = 1'b0; s_axi.wdata  = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0;
        s_axi.arvalid = 1'b0; s_axi.araddr = '0; s_axi.arid  = '0; s_axi.arlen = '0;
        s_axi.bready  = 1'b1;
        areset = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        check_val("rst_awready", s_axi.awready, 0);
        check_val("rst_arready", s_axi.arready, 0);
        check_val("rst_wready",  s_axi.wready,  0);
        check_val("rst_bvalid",  s_axi.bvalid,  0);
        check_val("rst_rvalid",  s_axi.rvalid,  0);
        check_val("rst_rdata",   s_axi.rdata,   0);
        check_val("rst_rlast",   s_axi.rlast,   0);
        check_val("rst_resp",    {s_axi.bresp, s_axi.rresp}, 0);
        check_val("rst_ids",     {s_axi.bid, s_axi.rid}, 0);
        areset = 1'b0;
        @(posedge ap_clk); #1;
        check_val("idle_awready", s_axi.awready, 1);
        check_val("idle_arready", s_axi.arready, 1);

        // Basic write then readback with first-beat latency.
        write_burst(64'h0, 8'd3, 1'b1, 512'd0, {64{1'b1}}, 1'b0);
        drain("wr_basic");
        read_burst(64'h0, 8'd3, 1'b1, 1'b1);
        drain("rd_basic");

        // Byte-enable merge on word 5.
        write_burst(64'h140, 8'd0, 1'b0, {512{1'b1}}, {64{1'b1}}, 1'b0);
        write_burst(64'h140, 8'd0, 1'b0, 512'd0, 64'h1, 1'b0);
        drain("wr_merge");
        check_val("merge_model", model[5], {{504{1'b1}}, 8'h00});
        read_burst(64'h140, 8'd0, 1'b0, 1'b0);
        drain("rd_merge");

        // Backpressure: 8-beat read with toggling rready.
        write_burst(64'h200, 8'd7, 1'b1, 512'd100, {64{1'b1}}, 1'b0);
        drain("wr_bp");
        rr_mode = 1;
        read_burst(64'h200, 8'd7, 1'b0, 1'b0);
        drain("rd_bp");
        rr_mode = 0;

        // wlast arriving early gives SLVERR.
        write_burst(64'h400, 8'd1, 1'b1, 512'd7, {64{1'b1}}, 1'b1);
        drain("wr_badlast");

        // Burst at the top word wraps to word 0 (or is rejected when bounds are checked).
        write_burst(64'hFFC0, 8'd1, 1'b0, 512'h55, {64{1'b1}}, 1'b0);
        drain("wr_wrap");
        read_burst(64'hFFC0, 8'd1, 1'b1, 1'b0);
        read_burst(64'h0, 8'd0, 1'b0, 1'b0);
        drain("rd_wrap");

        // Address above the RAM range.
        read_burst(64'h10000, 8'd0, 1'b1, 1'b0);
        drain("rd_bounds");

        // Reset in the middle of an 8-beat read.
        rr_mode = 0;
        base = r_beats;
        read_burst(64'h200, 8'd7, 1'b0, 1'b0);
        n = 0;
        while (r_beats < base + 3 && n < 100) begin
            @(posedge ap_clk); #1;
            n++;
        end
        check_val("rstmid_reach", (r_beats - base) >= 3, 1);
        areset  = 1'b1;
        rr_mode = 2;
        @(posedge ap_clk); #1;
        check_val("rstmid_rvalid",  s_axi.rvalid,  0);
        check_val("rstmid_bvalid",  s_axi.bvalid,  0);
        check_val("rstmid_rlast",   s_axi.rlast,   0);
        check_val("rstmid_arready", s_axi.arready, 0);
        exp_r.delete();
        @(posedge ap_clk); #1;
        areset  = 1'b0;
        rr_mode = 0;
        @(posedge ap_clk); #1;
        check_val("rstmid_idle", s_axi.arready, 1);
        read_burst(64'h200, 8'd7, 1'b1, 1'b1);
        drain("rd_after_rst");
        write_burst(64'h300, 8'd1, 1'b1, 512'd900, {64{1'b1}}, 1'b0);
        drain("wr_after_rst");
        read_burst(64'h300, 8'd1, 1'b0, 1'b0);
        read_burst(64'h0, 8'd3, 1'b1, 1'b0);
        drain("rd_after_rst2");

        check_val("sb_empty", exp_r.size() + exp_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
